// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants, line-fetch FSM states and pixel slice helper
package vga_pkg;
  localparam int H_DISPLAY = 640;
  localparam int H_FRONT = 16;
  localparam int H_SYNC = 96;
  localparam int H_BACK = 48;
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT = 10;
  localparam int V_SYNC = 2;
  localparam int V_BACK = 33;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int PIX_PER_WORD = 8;
  localparam int WORDS_PER_LINE = H_DISPLAY / PIX_PER_WORD;
  localparam int WORD_W = 3 * PIX_PER_WORD;
  localparam int WADDR_W = 7;
  localparam int ADDR_W = 16;
  localparam int BAR_W = H_DISPLAY / 8;
  typedef enum logic {IDLE, FETCH} fetch_state_t;
  function automatic logic [2:0] pix_of(input logic [WORD_W-1:0] w, input logic [2:0] p);
    return w[3*p +: 3];
  endfunction
endpackage

// File: rtl/vga_line_buf.sv
// vga_line_buf: one-line simple dual-port RAM, sync write port and sync read port
module vga_line_buf
  import vga_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [WADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0]  wdata,
  input  logic [WADDR_W-1:0] raddr,
  output logic [WORD_W-1:0]  rdata
);
  logic [WORD_W-1:0] mem [WORDS_PER_LINE];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/vga_line_fetch.sv
// vga_line_fetch: ping-pong line fetcher feeding the VGA timing stage with 2-cycle pixel latency.
// Define VGA_TEST_PATTERN_EN to add the pattern_en port and 8 vertical colour bars.
module vga_line_fetch
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [8:0]        fetch_line,
  input  logic              de,
`ifdef VGA_TEST_PATTERN_EN
  input  logic              pattern_en,
`endif
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_data,
  output logic              r,
  output logic              g,
  output logic              b,
  output logic              line_ready,
  output logic              underrun
);
  fetch_state_t state_q, state_d;
  logic bank_q, back_done_q, ack_ok, done;
  logic [8:0] line_q;
  logic [WADDR_W-1:0] word_q;
  logic [9:0] x_q;
  logic de_d1, bank_d1;
  logic [2:0] sel_d1, rgb_q;
  logic [WORD_W-1:0] rdata [2];
`ifdef VGA_TEST_PATTERN_EN
  logic pat_d1;
  logic [2:0] bar_d1;
`endif
  // an ack coinciding with fetch_req belongs to the aborted line and is dropped
  always_comb begin
    mem_req = state_q == FETCH;
    mem_addr = ADDR_W'(line_q) * ADDR_W'(WORDS_PER_LINE) + ADDR_W'(word_q);
    ack_ok = mem_req && mem_ack && !fetch_req;
    done = ack_ok && word_q == WADDR_W'(WORDS_PER_LINE - 1);
    state_d = fetch_req ? FETCH : done ? IDLE : state_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q <= 1'b0;
      back_done_q <= 1'b0;
      line_ready <= 1'b0;
      underrun <= 1'b0;
      line_q <= '0;
      word_q <= '0;
    end else if (fetch_req) begin
      bank_q <= ~bank_q;
      back_done_q <= 1'b0;
      line_ready <= back_done_q;
      underrun <= underrun | mem_req;
      line_q <= fetch_line;
      word_q <= '0;
    end else if (ack_ok) begin
      word_q <= done ? '0 : word_q + 1'b1;
      back_done_q <= back_done_q | done;
    end
  end
  // buffer bank_q is the front (display) side, the other one is being filled
  for (genvar i = 0; i < 2; i++) begin : g_buf
    vga_line_buf u_buf (
      .clk  (clk),
      .we   (ack_ok && bank_q != 1'(i)),
      .waddr(word_q),
      .wdata(mem_data),
      .raddr(x_q[9:3]),
      .rdata(rdata[i])
    );
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      de_d1 <= 1'b0;
      bank_d1 <= 1'b0;
      sel_d1 <= '0;
      rgb_q <= '0;
`ifdef VGA_TEST_PATTERN_EN
      pat_d1 <= 1'b0;
      bar_d1 <= '0;
`endif
    end else begin
      x_q <= de ? x_q + 1'b1 : '0;
      de_d1 <= de;
      bank_d1 <= bank_q;
      sel_d1 <= x_q[2:0];
`ifdef VGA_TEST_PATTERN_EN
      pat_d1 <= pattern_en;
      bar_d1 <= 3'(x_q / 10'(BAR_W));
      rgb_q <= !de_d1 ? '0 : pat_d1 ? bar_d1 : pix_of(rdata[bank_d1], sel_d1);
`else
      rgb_q <= de_d1 ? pix_of(rdata[bank_d1], sel_d1) : '0;
`endif
    end
  end
  assign {r, g, b} = rgb_q;
endmodule
